// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op encodings, FSM states and default width for the HI/LO divide controller.
package hilo_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIXUP} state_t;
endpackage

// File: rtl/hilo_sign_fix.sv
// hilo_sign_fix: conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module hilo_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = neg ? -val : val;
endmodule

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequences the shared divide engine and owns architectural HI/LO.
// HILO_DIV0_PRESERVE_EN: when defined, divide-by-zero leaves HI/LO untouched.
module hilo_div_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             op_ready,
    input  logic             rd_req,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             div0
);
`ifdef HILO_DIV0_PRESERVE_EN
    localparam bit PRESERVE = 1'b1;
`else
    localparam bit PRESERVE = 1'b0;
`endif
    state_t state;
    logic sq, sr, is_sdiv;
    logic [WIDTH-1:0] q_tmp, r_tmp, a_mag, b_mag, lo_fix, hi_fix;
    assign is_sdiv = op == OP_DIV;
    assign op_ready = state == IDLE;
    assign busy = state != IDLE;
    assign stall = rd_req && busy;
    assign div_start = state == ISSUE;
    hilo_sign_fix #(.W(WIDTH)) u_abs_a (.val(rs_val), .neg(is_sdiv && rs_val[WIDTH-1]), .res(a_mag));
    hilo_sign_fix #(.W(WIDTH)) u_abs_b (.val(rt_val), .neg(is_sdiv && rt_val[WIDTH-1]), .res(b_mag));
    hilo_sign_fix #(.W(WIDTH)) u_fix_q (.val(q_tmp), .neg(sq), .res(lo_fix));
    hilo_sign_fix #(.W(WIDTH)) u_fix_r (.val(r_tmp), .neg(sr), .res(hi_fix));
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            div0  <= 1'b0;
            div_a <= '0;
            div_b <= '0;
            sq    <= 1'b0;
            sr    <= 1'b0;
            q_tmp <= '0;
            r_tmp <= '0;
        end else begin
            case (state)
                IDLE: if (op_valid) begin
                    if (op == OP_MTHI) hi <= rs_val;
                    else if (op == OP_MTLO) lo <= rs_val;
                    else if (rt_val == '0) begin
                        div0 <= 1'b1;
                        if (!PRESERVE) begin
                            lo <= '1;
                            hi <= rs_val;
                        end
                    end else begin
                        div0  <= 1'b0;
                        sq    <= is_sdiv && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        sr    <= is_sdiv && rs_val[WIDTH-1];
                        div_a <= a_mag;
                        div_b <= b_mag;
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: if (div_done) begin
                    q_tmp <= div_q;
                    r_tmp <= div_r;
                    state <= FIXUP;
                end
                FIXUP: begin
                    lo    <= lo_fix;
                    hi    <= hi_fix;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: randomized scoreboard bench with a mock divide engine and an arithmetic reference model.
module tb_hilo_div_ctrl;
    logic clk = 0, reset, op_valid, rd_req, div_done, force_done;
    logic [1:0] op;
    logic [31:0] rs_val, rt_val, hi, lo, div_a, div_b, div_q, div_r;
    logic op_ready, stall, busy, div_start, div0;

    hilo_div_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .op_ready(op_ready), .rd_req(rd_req), .stall(stall), .hi(hi), .lo(lo), .busy(busy),
        .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done),
        .div_q(div_q), .div_r(div_r), .div0(div0)
    );

    always #5 clk = ~clk;

    // mock engine: latches magnitudes on start, pulses done after lat cycles
    int cnt = 0, lat = 4, starts = 0;
    logic [31:0] ea = 0, eb = 1;
    always @(posedge clk) begin
        if (reset) cnt <= 0;
        else if (div_start) begin
            cnt <= lat;
            ea <= div_a;
            eb <= div_b;
            starts <= starts + 1;
        end else if (cnt > 0) cnt <= cnt - 1;
    end
    assign div_done = (cnt == 1) || force_done;
    assign div_q = (eb == 0) ? 32'd0 : ea / eb;
    assign div_r = (eb == 0) ? 32'd0 : ea % eb;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
    } exp_t;
    exp_t scb[$];
    int n_pass = 0, n_total = 0;
    logic [31:0] m_hi = 0, m_lo = 0, exp_a = 0, exp_b = 0;
    logic m_div0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sd;
        if (o == 2'd2) m_hi = a;
        else if (o == 2'd3) m_lo = a;
        else if (b == 0) begin
            m_div0 = 1;
`ifndef HILO_DIV0_PRESERVE_EN
            m_lo = 32'hFFFFFFFF;
            m_hi = a;
`endif
        end else begin
            m_div0 = 0;
            if (o == 2'd0) begin
                exp_a = a[31] ? 32'd0 - a : a;
                exp_b = b[31] ? 32'd0 - b : b;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    m_lo = 32'h80000000;
                    m_hi = 0;
                end else begin
                    sa = a;
                    sd = b;
                    m_lo = sa / sd;
                    m_hi = sa % sd;
                end
            end else begin
                exp_a = a;
                exp_b = b;
                m_lo = a / b;
                m_hi = a % b;
            end
        end
    endfunction

    // monitor: pops an expectation whenever a result becomes architecturally visible
    logic pend = 0, prev_busy = 0;
    always @(negedge clk) begin
        if (reset) begin
            scb.delete();
            pend = 0;
            prev_busy = 0;
        end else begin
            if (pend || (prev_busy && !busy)) begin
                if (scb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got hi=%h lo=%h want none", hi, lo);
                end else begin
                    exp_t e;
                    e = scb.pop_front();
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    chk("div0", {31'd0, div0}, {31'd0, e.d0});
                end
            end
            pend = op_valid && op_ready && (op[1] || rt_val == 0);
            prev_busy = busy;
            if (busy) chk("div_ab_hold", {div_a ^ exp_a} | {div_b ^ exp_b}, 32'd0);
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int waited);
        op = o;
        rs_val = a;
        rt_val = b;
        op_valid = 1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (op_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) begin
            n_total++;
            $display("FAIL accept_timeout: got op_ready=0 want 1");
        end else begin
            model(o, a, b);
            scb.push_back('{m_hi, m_lo, m_div0});
        end
        @(posedge clk);
        #1 op_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                n_total++;
                $display("FAIL idle_timeout: got busy=1 want 0");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, s0, ns, n;
        logic [31:0] a, b;
        reset = 1; op_valid = 0; op = 0; rs_val = 0; rt_val = 0; rd_req = 1; force_done = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_div0", {31'd0, div0}, 0);
        chk("rst_ready", {31'd0, op_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_start", {31'd0, div_start}, 0);
        chk("rst_ab", div_a | div_b, 0);
        @(posedge clk);
        #1 reset = 0;

        // DIVU 100/7, 32-cycle engine, reads stalled for the whole flight
        lat = 32;
        s0 = starts;
        do_op(2'd1, 100, 7, w);
        ns = 0;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            if (stall) ns++;
            n++;
            @(negedge clk);
        end
        chk("stall_cycles", ns, 34);
        chk("stall_after", {31'd0, stall}, 0);
        chk("start_once", starts - s0, 1);
        @(posedge clk);
        #1 rd_req = 0;

        lat = 3;
        do_op(2'd0, 32'hFFFFFFF9, 2, w);
        wait_idle();
        do_op(2'd0, 32'h80000000, 32'hFFFFFFFF, w);
        wait_idle();

        s0 = starts;
        do_op(2'd1, 5, 0, w);
        wait_idle();
        chk("div0_no_start", starts - s0, 0);
        do_op(2'd1, 9, 3, w);
        wait_idle();

        // MTHI held while a divide is in flight
        lat = 10;
        do_op(2'd1, 1000, 10, w);
        do_op(2'd2, 32'hDEAD, 0, w);
        chk("mthi_held", w, 12);
        wait_idle();

        // reset in WAIT, then a stray done
        lat = 20;
        do_op(2'd0, 1000, 3, w);
        repeat (5) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        m_hi = 0; m_lo = 0; m_div0 = 0;
        @(negedge clk);
        chk("rstw_busy", {31'd0, busy}, 0);
        chk("rstw_hi", hi, 0);
        chk("rstw_lo", lo, 0);
        @(posedge clk);
        #1 force_done = 1;
        @(posedge clk);
        #1 force_done = 0;
        @(negedge clk);
        chk("late_done_busy", {31'd0, busy}, 0);
        chk("late_done_lo", lo, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            lat = $urandom_range(1, 6);
            rd_req = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 1000);
                1: a = $urandom;
                2: a = 32'h80000000;
                default: a = 32'd0 - $urandom_range(1, 1000);
            endcase
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = 32'hFFFFFFFF;
                2, 3: b = $urandom_range(1, 50);
                4: b = 32'd0 - $urandom_range(1, 50);
                default: b = $urandom;
            endcase
            do_op(2'($urandom_range(0, 3)), a, b, w);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", scb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
